// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: matrix pins plus the key stream handed to the
// code-entry checker. The scanner takes the master side.
interface keypad_scanner_if;
    logic [3:0] row;         // row returns, active-low, asynchronous
    logic [3:0] col;         // column drives, active-low, one bit low
    logic [3:0] button;      // code of the accepted key
    logic       bstate;      // high while the accepted key is held
    logic       key_strobe;  // one-cycle pulse as bstate falls

    modport master (
        input  row,
        output col,
        output button,
        output bstate,
        output key_strobe
    );

    modport slave (
        output row,
        input  col,
        input  button,
        input  bstate,
        input  key_strobe
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, synchronizes
// and debounces the row returns, and reports a single held key as a 4-bit code
// with a level strobe (bstate) and a release pulse (key_strobe).
module keypad_scanner #(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input logic              hwclk,
    input logic              reset,
    keypad_scanner_if.master kp
);

    localparam int unsigned SlotW = $clog2(SCAN_DIV);
    localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0]  CntLast  = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_CYCLES);
    localparam logic [3:0]       ColFirst = 4'b1110;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StHeld,
        StRelDb
    } state_e;

    // Row synchronizer
    logic [3:0] row_meta_q;
    logic [3:0] rs_q;

    // Control state
    state_e            state_q, state_d;
    logic [SlotW-1:0]  slot_q, slot_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        col_q, col_d;
    logic [1:0]        cap_row_q, cap_row_d;

    // Key stream outputs
    logic [3:0]        button_q, button_d;
    logic              bstate_q, bstate_d;
    logic              key_strobe_q, key_strobe_d;

    // Derived values
    logic              rs_any_low;
    logic [1:0]        low_row;
    logic [1:0]        col_idx;
    logic              cap_rs;
    logic [CntW-1:0]   cnt_inc;
    logic [3:0]        col_next;

    // Keypad legend for (row, column); star and hash sit at 14 and 15.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0:    code = 4'd1;
            4'h1:    code = 4'd2;
            4'h2:    code = 4'd3;
            4'h3:    code = 4'd10;
            4'h4:    code = 4'd4;
            4'h5:    code = 4'd5;
            4'h6:    code = 4'd6;
            4'h7:    code = 4'd11;
            4'h8:    code = 4'd7;
            4'h9:    code = 4'd8;
            4'ha:    code = 4'd9;
            4'hb:    code = 4'd12;
            4'hc:    code = 4'd14;
            4'hd:    code = 4'd0;
            4'he:    code = 4'd15;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer for the asynchronous rows; idles high like the pull-ups.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            row_meta_q <= 4'hf;
            rs_q       <= 4'hf;
        end else begin
            row_meta_q <= kp.row;
            rs_q       <= row_meta_q;
        end
    end

    // Row priority, column index and counter helpers used by the next-state logic.
    always_comb begin
        rs_any_low = ~&rs_q;
        if (!rs_q[0]) begin
            low_row = 2'd0;
        end else if (!rs_q[1]) begin
            low_row = 2'd1;
        end else if (!rs_q[2]) begin
            low_row = 2'd2;
        end else begin
            low_row = 2'd3;
        end

        unique case (col_q)
            4'b1110: col_idx = 2'd0;
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase

        cap_rs   = rs_q[cap_row_q];
        // Saturate rather than wrap so a stuck count can never alias to zero.
        cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        col_next = {col_q[2:0], col_q[3]};
    end

    // Next-state and output decisions for scan / debounce / hold / release.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        cap_row_d    = cap_row_q;
        button_d     = button_q;
        bstate_d     = bstate_q;
        key_strobe_d = 1'b0;

        unique case (state_q)
            StScan: begin
                if (slot_q == SlotLast) begin
                    slot_d = '0;
                    // The slot-end sample still sees the column driven this slot;
                    // on a hit the column stays put instead of rotating.
                    if (rs_any_low) begin
                        state_d   = StPressDb;
                        cap_row_d = low_row;
                        cnt_d     = '0;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end

            StPressDb: begin
                if (!cap_rs) begin
                    // Comparing against the last count accepts on the sample
                    // that brings the count to DEBOUNCE_CYCLES.
                    if (cnt_q == CntLast) begin
                        state_d  = StHeld;
                        button_d = key_code(cap_row_q, col_idx);
                        bstate_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    // Bounce: give up on this key and move on to the next column.
                    state_d = StScan;
                    col_d   = col_next;
                    slot_d  = '0;
                    cnt_d   = '0;
                end
            end

            StHeld: begin
                if (cap_rs) begin
                    state_d = StRelDb;
                    cnt_d   = '0;
                end
            end

            StRelDb: begin
                if (cap_rs) begin
                    if (cnt_q == CntLast) begin
                        state_d      = StScan;
                        bstate_d     = 1'b0;
                        key_strobe_d = 1'b1;
                        col_d        = ColFirst;
                        slot_d       = '0;
                        cnt_d        = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end
            end

            default: begin
                state_d = StScan;
            end
        endcase
    end

    // Control and output registers; reset drops bstate without a strobe.
    always_ff @(posedge hwclk) begin
        if (reset) begin
            state_q      <= StScan;
            slot_q       <= '0;
            cnt_q        <= '0;
            col_q        <= ColFirst;
            cap_row_q    <= 2'd0;
            button_q     <= 4'd0;
            bstate_q     <= 1'b0;
            key_strobe_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            cap_row_q    <= cap_row_d;
            button_q     <= button_d;
            bstate_q     <= bstate_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    assign kp.col        = col_q;
    assign kp.button     = button_q;
    assign kp.bstate     = bstate_q;
    assign kp.key_strobe = key_strobe_q;

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Drives and reads the 4x4 matrix keypad and produces the `button`/`bstate` key stream consumed by the lock's code-entry validity checker. It scans columns, synchronizes and debounces the row returns, and encodes a single held key to a 4-bit code. It presents that code with a level strobe, `bstate`, which is high while the key is held. Consumers register the key on the falling edge of `bstate`, on release.

## Interface

Parameters:
- `SCAN_DIV`, default 1000: `hwclk` cycles per column slot; minimum 4.
- `DEBOUNCE_CYCLES`, default 20000: consecutive stable synchronized samples required to accept a press or a release; minimum 2.

Ports:
- `hwclk`, input, 1: the single clock for the whole block.
- `reset`, input, 1: synchronous, active-high reset.
- `row`, input, 4: keypad row returns; active-low, externally pulled up, asynchronous to `hwclk`.
- `col`, output, 4: column drives; active-low, exactly one bit low at all times.
- `button`, output, 4: code of the accepted key.
- `bstate`, output, 1: high while the accepted key is held after debounce.
- `key_strobe`, output, 1: one-cycle pulse on the cycle `bstate` falls.

## Operation

- **Key map, row r / col c:**
  - r0 gives 1, 2, 3, A → 1, 2, 3, 10.
  - r1 gives 4, 5, 6, B → 4, 5, 6, 11.
  - r2 gives 7, 8, 9, C → 7, 8, 9, 12.
  - r3 gives *, 0, #, D → 14, 0, 15, 13.
- **Row synchronization:** `row` passes through a 2-flop synchronizer. All decisions use the synchronized value `rs`.
- **SCAN:**
  - `col` rotates 1110 → 1101 → 1011 → 0111 → 1110, advancing every `SCAN_DIV` cycles.
  - `rs` is sampled on the last cycle of each slot.
  - If any `rs` bit is low, capture (row, col) and go to PRESS_DB. The lowest-index low row wins.
  - On capture, `col` freezes on the captured column.
- **PRESS_DB:**
  - The counter increments each cycle the captured `rs` bit is low.
  - A high sample returns to SCAN; rotation resumes from the next column.
  - When the counter reaches `DEBOUNCE_CYCLES`: go to HELD, load `button` with the code, set `bstate` to 1.
- **HELD:**
  - Stay while the captured `rs` bit is low.
  - On a high sample, go to REL_DB with the counter cleared.
  - Other keys are ignored. `col` stays frozen, so only the captured column is observed.
- **REL_DB:**
  - The counter increments each cycle the captured `rs` bit is high.
  - A low sample returns to HELD; `bstate` stays 1.
  - When the counter reaches `DEBOUNCE_CYCLES`:
    - set `bstate` to 0 and pulse `key_strobe`;
    - go to SCAN with `col` = 1110 and the slot counter cleared.
- **Output hold:** `button` changes only when entering HELD. It holds its value after release until the next accepted press.
- **Reset values:**
  - SCAN, `col` = 1110, `button` = 0, `bstate` = 0, `key_strobe` = 0.
  - All counters and synchronizer flops are 0 / 1 (idle-high rows).
- **Reset mid-operation:**
  - Reset in HELD or REL_DB drops `bstate` without a `key_strobe` pulse.
  - The downstream checker shares `reset`, so this falling edge is not treated as a key.
- **Width rules:**
  - The debounce counter is sized `$clog2(DEBOUNCE_CYCLES+1)` and saturates; it never wraps.
  - The slot counter is sized `$clog2(SCAN_DIV)` and wraps at `SCAN_DIV-1`.

## Timing

- Row input to `rs`: 2 cycles.
- Press latency: `bstate` rises `DEBOUNCE_CYCLES`+1 cycles after the detecting slot sample, provided every intervening `rs` sample is low.
- Release latency: `bstate` falls `DEBOUNCE_CYCLES`+1 cycles after the first high `rs` sample, provided none of the following samples is low. `key_strobe` is high on exactly that cycle.
- Minimum `bstate` high time: `DEBOUNCE_CYCLES`+1 cycles.
- Minimum gap between two `bstate` pulses: one full `SCAN_DIV` slot plus the press debounce.
- `button` is stable at least `DEBOUNCE_CYCLES` cycles before and after every `bstate` falling edge, so it is safe to sample on `negedge bstate`.
- Simultaneous events:
  - If the slot-end sample and the rotation fall on the same cycle, the sample takes the pre-rotation `rs`.
  - If reset and any other transition coincide, reset wins.

## Test plan

Bench parameters: `SCAN_DIV`=4, `DEBOUNCE_CYCLES`=8; the keypad model shorts row r to `col[c]` while key (r, c) is pressed.

1. **Reset:** assert `reset` 3 cycles mid-rotation → next cycle `col`=1110, `button`=0, `bstate`=0, `key_strobe`=0; rotation restarts 4 cycles per column.
2. **Single key:** press key '5' (r1, c1) for 60 cycles, then release → `bstate` rises with `button`=5 and `col` frozen at 1101. `bstate` falls 9 cycles after the `rs` release, with one `key_strobe` pulse. `col`=1110 the next cycle.
3. **Press bounce:** key '0' (r3, c1) low for 4 cycles, then high → `bstate` never rises and scanning resumes at column 2. A clean press then yields `button`=0.
4. **Release bounce:** while key '9' is HELD, glitch `row[2]` high for 3 cycles, then low for 20, then release cleanly → exactly one `bstate` pulse with `button`=9 and one `key_strobe`.
5. **Multi-key:**
   - hold '1'; after acceptance also press '9' (different column) → `button` stays 1 and one pulse results;
   - hold '4' and '7' together (same column) → `button`=4.
6. **Sequence and reset:**
   - enter 1, 2, 3, 4, 5, 6 with 30-cycle presses and gaps → six `bstate` falling edges carrying codes 1–6 in order;
   - assert reset during HELD → `bstate`=0 next cycle, no `key_strobe`.
